seg7_scan_driver: RTL and testbench

//  Time-multiplexed 7-segment display driver. Sits downstream of the cascaded dec_counter chain.
//  - Takes the packed BCD digit vector the chain produces.
//  - Scans the digits one at a time onto the shared segment bus, with dead time between digits.
//  - Snapshots the digits once per frame so a display never shows a half-updated count.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high glyphs {g,f,e,d,c,b,a}
// and the scan FSM state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment glyph; non-decimal codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (nibble)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame digit snapshot, blank/show slot FSM,
// leading-zero blanking and registered, polarity-configurable outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SCAN_DIV - DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return (SEG_ACT_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return (SEG_ACT_LOW != 0) ? ~d : d;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] dig_pol(input logic [NUM_DIGITS-1:0] d);
    return (DIG_ACT_LOW != 0) ? ~d : d;
  endfunction

  scan_state_t             state, state_nxt;
  logic [TW-1:0]           timer, timer_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    load;
  logic                    tick_nxt;

  logic [4*NUM_DIGITS-1:0] shadow_bcd, shadow_bcd_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt;
  logic                    shadow_lz, shadow_lz_nxt;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_above;
  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic                    blank_sel;
  logic [6:0]              glyph;

  logic [6:0]              seg_act;
  logic                    dp_act;
  logic [NUM_DIGITS-1:0]   dig_act;

  logic [6:0]              seg_p0;
  logic                    dp_p0;
  logic [NUM_DIGITS-1:0]   dig_p0;
  logic                    tick_p0;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    idx_nxt   = idx;
    load      = 1'b0;
    tick_nxt  = 1'b0;
    case (state)
      ST_BLANK: begin
        if (timer == DEAD_LAST) begin
          state_nxt = ST_SHOW;
          timer_nxt = '0;
          if (idx == '0) begin
            load     = 1'b1;
            tick_nxt = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        if (timer == SHOW_LAST) begin
          state_nxt = ST_BLANK;
          timer_nxt = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        timer_nxt = '0;
      end
    endcase
  end

  // The snapshot is taken on the same edge that lights digit 0, so decode from the next-shadow view.
  always_comb begin
    shadow_bcd_nxt = load ? bcd_in   : shadow_bcd;
    shadow_dp_nxt  = load ? dp_in    : shadow_dp;
    shadow_lz_nxt  = load ? lz_blank : shadow_lz;
  end

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shadow_bcd_nxt[4*k +: 4] == 4'd0);
      lz_mask[k] = shadow_lz_nxt && zero_above && (k != 0);
    end
  end

  always_comb begin
    nib_sel   = 4'd0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    dig_act   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib_sel    = shadow_bcd_nxt[4*k +: 4];
        dp_sel     = shadow_dp_nxt[k];
        blank_sel  = lz_mask[k];
        dig_act[k] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .nibble (nib_sel),
    .glyph  (glyph)
  );

  always_comb begin
    seg_act = SEG_OFF;
    dp_act  = 1'b0;
    if (state_nxt == ST_SHOW) begin
      seg_act = blank_sel ? SEG_OFF : glyph;
      dp_act  = dp_sel;
    end
  end

  // Output register stage: polarity applied here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      timer      <= '0;
      idx        <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      shadow_lz  <= 1'b0;
      seg_p0     <= seg_pol(SEG_OFF);
      dp_p0      <= dp_pol(1'b0);
      dig_p0     <= dig_pol('0);
      tick_p0    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      idx        <= idx_nxt;
      shadow_bcd <= shadow_bcd_nxt;
      shadow_dp  <= shadow_dp_nxt;
      shadow_lz  <= shadow_lz_nxt;
      seg_p0     <= seg_pol(seg_act);
      dp_p0      <= dp_pol(dp_act);
      dig_p0     <= dig_pol((state_nxt == ST_SHOW) ? dig_act : '0);
      tick_p0    <= tick_nxt;
    end
  end

  assign seg_out    = seg_p0;
  assign dp_out     = dp_p0;
  assign dig_sel    = dig_p0;
  assign frame_tick = tick_p0;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead cycles, active-low outputs).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (8),
    .DEAD_CYCLES (2),
    .SEG_ACT_LOW (1),
    .DIG_ACT_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] seg_exp;  // {d3,d2,d1,d0}, active-low
    logic [3:0]  dp_exp;   // per digit, active-low
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: frame_tick not seen within 40 cycles", name);
    end
  endtask

  // Called at the negedge where frame_tick is high; returns at the next frame's tick.
  task automatic check_frame(input int v);
    logic [3:0] de;
    for (int d = 0; d < 4; d++) begin
      de = ~(4'b0001 << d);
      chk($sformatf("v%0d_d%0d_dig", v, d), dig_sel, de);
      chk($sformatf("v%0d_d%0d_seg", v, d), seg_out, vecs[v].seg_exp[7*d +: 7]);
      chk($sformatf("v%0d_d%0d_dp", v, d), dp_out, vecs[v].dp_exp[d]);
      if (d == 0) chk($sformatf("v%0d_tick_hi", v), frame_tick, 1'b1);
      step(6);
      chk($sformatf("v%0d_d%0d_blank_dig", v, d), dig_sel, 4'hF);
      chk($sformatf("v%0d_d%0d_blank_seg", v, d), seg_out, 7'h7F);
      chk($sformatf("v%0d_d%0d_blank_dp", v, d), dp_out, 1'b1);
      chk($sformatf("v%0d_d%0d_tick_lo", v, d), frame_tick, 1'b0);
      step(2);
    end
    chk($sformatf("v%0d_period", v), frame_tick, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{16'h00A9, 4'b0010, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h10}, 4'b1101};
    vecs[4] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[5] = '{16'h8765, 4'b1001, 1'b0, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b0110};
    vecs[6] = '{16'h0F00, 4'b0000, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40}, 4'b1111};
    vecs[7] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};

    rst      = 1'b1;
    bcd_in   = 16'h1234;
    dp_in    = 4'b0000;
    lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig", dig_sel, 4'hF);
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    step(1);
    chk("rel_e1_tick", frame_tick, 1'b0);
    chk("rel_e1_dig", dig_sel, 4'hF);
    step(1);
    chk("rel_e2_tick", frame_tick, 1'b1);
    chk("rel_e2_dig", dig_sel, 4'hE);
    chk("rel_e2_seg", seg_out, 7'h19);
    for (int i = 1; i < 6; i++) begin
      step(1);
      chk($sformatf("rel_show%0d_dig", i), dig_sel, 4'hE);
      chk($sformatf("rel_show%0d_tick", i), frame_tick, 1'b0);
    end
    step(1);
    chk("rel_dead_dig", dig_sel, 4'hF);

    for (int v = 0; v < 8; v++) begin
      bcd_in   = vecs[v].bcd;
      dp_in    = vecs[v].dp;
      lz_blank = vecs[v].lz;
      wait_tick($sformatf("v%0d_wait", v));
      check_frame(v);
    end

    // Snapshot: inputs change during digit 2 SHOW must not reach the display until next frame.
    dp_in    = 4'b0000;
    lz_blank = 1'b0;
    bcd_in   = 16'h1111;
    wait_tick("snap_wait");
    step(17);
    chk("snap_d2_dig", dig_sel, 4'hB);
    chk("snap_d2_seg_pre", seg_out, 7'h79);
    bcd_in = 16'h2222;
    step(1);
    chk("snap_d2_seg_post", seg_out, 7'h79);
    step(6);
    chk("snap_d3_dig", dig_sel, 4'h7);
    chk("snap_d3_seg", seg_out, 7'h79);
    step(8);
    chk("snap_next_tick", frame_tick, 1'b1);
    chk("snap_next_dig", dig_sel, 4'hE);
    chk("snap_next_seg", seg_out, 7'h24);

    // Mid-scan reset during digit 2 SHOW.
    wait_tick("mrst_wait");
    step(18);
    chk("mrst_pre_dig", dig_sel, 4'hB);
    rst = 1'b1;
    step(1);
    chk("mrst_dig", dig_sel, 4'hF);
    chk("mrst_seg", seg_out, 7'h7F);
    chk("mrst_dp", dp_out, 1'b1);
    chk("mrst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    step(1);
    chk("mrst_e1_dig", dig_sel, 4'hF);
    chk("mrst_e1_tick", frame_tick, 1'b0);
    step(1);
    chk("mrst_e2_tick", frame_tick, 1'b1);
    chk("mrst_e2_dig", dig_sel, 4'hE);
    chk("mrst_e2_seg", seg_out, 7'h24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
